// File: rtl/pc_gen_btb.sv
// -----------------------------------------------------------------------------
// pc_gen_btb
//
// Fetch-PC generator with a prioritised trap/redirect path and a direct-mapped
// branch target buffer (BTB) used to predict the next fetch address.
//
// Next-PC priority (first match wins): trap, redirect, stall, BTB hit,
// sequential increment. Every loaded address has bits [1:0] forced to zero,
// so pc_o is always word aligned.
//
// Ports:
//   clk               clock
//   rst               synchronous reset, active-high
//   stall_i           hold the current PC (no new fetch)
//   trap_valid_i      trap/exception redirect request
//   trap_pc_i         trap handler address
//   redirect_valid_i  mispredict redirect from EX
//   redirect_pc_i     corrected PC
//   btb_upd_valid_i   BTB update strobe from EX
//   btb_upd_pc_i      PC of the resolved control-transfer instruction
//   btb_upd_target_i  resolved target
//   btb_upd_taken_i   resolved outcome, 1 = taken
//   pc_o              current fetch PC
//   pc_valid_o        pc_o was loaded at the last edge (new fetch)
//   pred_taken_o      BTB hit for pc_o (combinational)
//   pred_target_o     BTB target for pc_o, zero when no hit
//   flush_o           a trap or redirect was taken at the last edge
// -----------------------------------------------------------------------------
module pc_gen_btb #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h00000000,
    parameter int                BTB_DEPTH = 8,
    parameter int                INC       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              trap_valid_i,
    input  logic [ADDR_W-1:0] trap_pc_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              btb_upd_valid_i,
    input  logic [ADDR_W-1:0] btb_upd_pc_i,
    input  logic [ADDR_W-1:0] btb_upd_target_i,
    input  logic              btb_upd_taken_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic              flush_o
);

    localparam int                IDX_W      = $clog2(BTB_DEPTH);
    localparam int                TAG_W      = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Clears the byte-offset bits so every loaded address is word aligned.
    function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] addr);
        f_align = addr & ALIGN_MASK;
    endfunction

    // ------------------------------------------------------------------ state
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 pc_valid_q, pc_valid_d;
    logic                 flush_q, flush_d;

    logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt_q [BTB_DEPTH];

    // ----------------------------------------------------------------- lookup
    logic [IDX_W-1:0]     look_idx_s;
    logic [TAG_W-1:0]     look_tag_s;
    logic                 hit_s;
    logic [ADDR_W-1:0]    hit_tgt_s;

    assign look_idx_s = pc_q[IDX_W+1:2];
    assign look_tag_s = pc_q[ADDR_W-1:IDX_W+2];

    // BTB read for the current fetch PC; stored targets are already aligned.
    always_comb begin
        hit_s     = 1'b0;
        hit_tgt_s = '0;
        if (btb_valid_q[look_idx_s] && (btb_tag_q[look_idx_s] == look_tag_s)) begin
            hit_s     = 1'b1;
            hit_tgt_s = btb_tgt_q[look_idx_s];
        end else begin
            hit_s     = 1'b0;
            hit_tgt_s = '0;
        end
    end

    // ---------------------------------------------------------------- next PC
    // Prioritised next-PC selection; trap and redirect win over stall.
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b0;
        flush_d    = 1'b0;
        if (trap_valid_i) begin
            pc_d       = f_align(trap_pc_i);
            pc_valid_d = 1'b1;
            flush_d    = 1'b1;
        end else if (redirect_valid_i) begin
            pc_d       = f_align(redirect_pc_i);
            pc_valid_d = 1'b1;
            flush_d    = 1'b1;
        end else if (stall_i) begin
            pc_d       = pc_q;
            pc_valid_d = 1'b0;
            flush_d    = 1'b0;
        end else if (hit_s) begin
            pc_d       = hit_tgt_s;
            pc_valid_d = 1'b1;
            flush_d    = 1'b0;
        end else begin
            // Sequential step wraps naturally modulo 2^ADDR_W.
            pc_d       = pc_q + INC_V;
            pc_valid_d = 1'b1;
            flush_d    = 1'b0;
        end
    end

    // PC, valid strobe and flush registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
        end
    end

    // ------------------------------------------------------------- BTB update
    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             btb_wr_s;
    logic             unused_upd_pc_lsb_s;

    assign upd_idx_s           = btb_upd_pc_i[IDX_W+1:2];
    assign upd_tag_s           = btb_upd_pc_i[ADDR_W-1:IDX_W+2];
    // The byte offset of the branch PC never selects an entry.
    assign unused_upd_pc_lsb_s = ^btb_upd_pc_i[1:0];

    // Taken outcomes allocate/overwrite; not-taken evicts only on a tag match.
    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_wr_s    = 1'b0;
        if (btb_upd_valid_i && !rst) begin
            if (btb_upd_taken_i) begin
                btb_valid_d[upd_idx_s] = 1'b1;
                btb_wr_s               = 1'b1;
            end else if (btb_valid_q[upd_idx_s] && (btb_tag_q[upd_idx_s] == upd_tag_s)) begin
                btb_valid_d[upd_idx_s] = 1'b0;
                btb_wr_s               = 1'b0;
            end else begin
                btb_valid_d = btb_valid_q;
                btb_wr_s    = 1'b0;
            end
        end else begin
            btb_valid_d = btb_valid_q;
            btb_wr_s    = 1'b0;
        end
    end

    // BTB valid bits; the only BTB state that needs a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
        end
    end

    // BTB tag/target storage; contents are ignored while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (btb_wr_s) begin
            btb_tag_q[upd_idx_s] <= upd_tag_s;
            btb_tgt_q[upd_idx_s] <= f_align(btb_upd_target_i);
        end
    end

    // ---------------------------------------------------------------- outputs
    assign pc_o          = pc_q;
    assign pc_valid_o    = pc_valid_q;
    assign flush_o       = flush_q;
    assign pred_taken_o  = hit_s;
    assign pred_target_o = hit_tgt_s;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Testbench for pc_gen_btb: directed vector table followed by random stimulus
// checked against an arithmetic reference model of the fetch-PC rules.
module tb_pc_gen_btb;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              stall_i;
    logic              trap_valid_i;
    logic [ADDR_W-1:0] trap_pc_i;
    logic              redirect_valid_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              btb_upd_valid_i;
    logic [ADDR_W-1:0] btb_upd_pc_i;
    logic [ADDR_W-1:0] btb_upd_target_i;
    logic              btb_upd_taken_i;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              flush_o;

    int checks = 0;
    int errors = 0;

    pc_gen_btb #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h00000000),
        .BTB_DEPTH(DEPTH),
        .INC      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .trap_valid_i    (trap_valid_i),
        .trap_pc_i       (trap_pc_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .btb_upd_valid_i (btb_upd_valid_i),
        .btb_upd_pc_i    (btb_upd_pc_i),
        .btb_upd_target_i(btb_upd_target_i),
        .btb_upd_taken_i (btb_upd_taken_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o),
        .flush_o         (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic        rst, stall, trap_v, redir_v, upd_v, upd_tk;
        logic [31:0] trap_pc, redir_pc, upd_pc, upd_tgt;
        logic [31:0] e_pc;
        logic        e_valid, e_flush, e_pred;
        logic [31:0] e_ptgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v_idle();
        vec_t v;
        v.rst = 1'b0; v.stall = 1'b0; v.trap_v = 1'b0; v.redir_v = 1'b0;
        v.upd_v = 1'b0; v.upd_tk = 1'b0;
        v.trap_pc = 32'h0; v.redir_pc = 32'h0; v.upd_pc = 32'h0; v.upd_tgt = 32'h0;
        v.e_pc = 32'h0; v.e_valid = 1'b0; v.e_flush = 1'b0; v.e_pred = 1'b0;
        v.e_ptgt = 32'h0;
        return v;
    endfunction

    function automatic vec_t v_rst(vec_t v);
        v.rst = 1'b1; return v;
    endfunction
    function automatic vec_t v_stall(vec_t v);
        v.stall = 1'b1; return v;
    endfunction
    function automatic vec_t v_trap(vec_t v, logic [31:0] a);
        v.trap_v = 1'b1; v.trap_pc = a; return v;
    endfunction
    function automatic vec_t v_redir(vec_t v, logic [31:0] a);
        v.redir_v = 1'b1; v.redir_pc = a; return v;
    endfunction
    function automatic vec_t v_upd(vec_t v, logic [31:0] pc, logic [31:0] tgt, logic tk);
        v.upd_v = 1'b1; v.upd_pc = pc; v.upd_tgt = tgt; v.upd_tk = tk; return v;
    endfunction

    task automatic add(vec_t v, logic [31:0] pc, logic val, logic fl, logic pr, logic [31:0] pt);
        v.e_pc = pc; v.e_valid = val; v.e_flush = fl; v.e_pred = pr; v.e_ptgt = pt;
        vecs.push_back(v);
    endtask

    // -------------------------------------------------------- reference model
    logic [31:0] m_pc;
    bit          m_valid, m_flush;
    bit          m_bv   [DEPTH];
    logic [31:0] m_bpc  [DEPTH];
    logic [31:0] m_btgt [DEPTH];

    function automatic int unsigned m_index(logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    function automatic logic [31:0] m_tag(logic [31:0] a);
        return a / (4 * DEPTH);
    endfunction

    function automatic logic [31:0] m_align(logic [31:0] a);
        return a - (a % 4);
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        int unsigned i = m_index(a);
        return m_bv[i] && (m_tag(m_bpc[i]) == m_tag(a));
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] a);
        return m_hit(a) ? m_btgt[m_index(a)] : 32'h0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit          hit;
        logic [31:0] tgt;
        int unsigned ui;
        hit = m_hit(m_pc);
        tgt = m_target(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_bv[i] = 1'b0;
        end else begin
            if (trap_valid_i) begin
                m_pc = m_align(trap_pc_i); m_valid = 1'b1; m_flush = 1'b1;
            end else if (redirect_valid_i) begin
                m_pc = m_align(redirect_pc_i); m_valid = 1'b1; m_flush = 1'b1;
            end else if (stall_i) begin
                m_valid = 1'b0; m_flush = 1'b0;
            end else if (hit) begin
                m_pc = tgt; m_valid = 1'b1; m_flush = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4; m_valid = 1'b1; m_flush = 1'b0;
            end
            if (btb_upd_valid_i) begin
                ui = m_index(btb_upd_pc_i);
                if (btb_upd_taken_i) begin
                    m_bv[ui]   = 1'b1;
                    m_bpc[ui]  = btb_upd_pc_i;
                    m_btgt[ui] = m_align(btb_upd_target_i);
                end else if (m_bv[ui] && m_tag(m_bpc[ui]) == m_tag(btb_upd_pc_i)) begin
                    m_bv[ui] = 1'b0;
                end
            end
        end
    endtask

    // ---------------------------------------------------------------- helpers
    task automatic drive(vec_t v);
        rst = v.rst; stall_i = v.stall;
        trap_valid_i = v.trap_v; trap_pc_i = v.trap_pc;
        redirect_valid_i = v.redir_v; redirect_pc_i = v.redir_pc;
        btb_upd_valid_i = v.upd_v; btb_upd_pc_i = v.upd_pc;
        btb_upd_target_i = v.upd_tgt; btb_upd_taken_i = v.upd_tk;
    endtask

    task automatic cmp(string nm, logic [31:0] epc, logic ev, logic ef, logic ep, logic [31:0] ept);
        checks++;
        if (pc_o !== epc || pc_valid_o !== ev || flush_o !== ef ||
            pred_taken_o !== ep || pred_target_o !== ept) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b f=%b p=%b t=%h, want pc=%h v=%b f=%b p=%b t=%h",
                     nm, pc_o, pc_valid_o, flush_o, pred_taken_o, pred_target_o,
                     epc, ev, ef, ep, ept);
        end
    endtask

    // ------------------------------------------------------------------- test
    initial begin
        vec_t v;
        for (int i = 0; i < DEPTH; i++) begin
            m_bv[i] = 1'b0; m_bpc[i] = 32'h0; m_btgt[i] = 32'h0;
        end
        m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0;
        drive(v_rst(v_idle()));

        // Reset and sequential fetch.
        add(v_rst(v_idle()),  32'h0,   1'b0, 1'b0, 1'b0, 32'h0);
        add(v_rst(v_idle()),  32'h0,   1'b0, 1'b0, 1'b0, 32'h0);
        add(v_idle(),         32'h4,   1'b1, 1'b0, 1'b0, 32'h0);
        add(v_idle(),         32'h8,   1'b1, 1'b0, 1'b0, 32'h0);
        add(v_idle(),         32'hC,   1'b1, 1'b0, 1'b0, 32'h0);
        add(v_idle(),         32'h10,  1'b1, 1'b0, 1'b0, 32'h0);
        // Stall holds, redirect overrides stall, flush lasts one cycle.
        add(v_stall(v_idle()), 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        add(v_stall(v_idle()), 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        add(v_stall(v_idle()), 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_stall(v_idle()), 32'h200), 32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
        add(v_idle(),         32'h204, 1'b1, 1'b0, 1'b0, 32'h0);
        // Trap beats redirect.
        add(v_redir(v_trap(v_idle(), 32'h80), 32'h300), 32'h80, 1'b1, 1'b1, 1'b0, 32'h0);
        // Train 0x20->0x100, predict, follow, evict.
        add(v_upd(v_idle(), 32'h20, 32'h100, 1'b1), 32'h84, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h20), 32'h20,  1'b1, 1'b1, 1'b1, 32'h100);
        add(v_idle(),         32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_idle(),         32'h104, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_upd(v_idle(), 32'h20, 32'h0, 1'b0), 32'h108, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h20), 32'h20,  1'b1, 1'b1, 1'b0, 32'h0);
        add(v_idle(),         32'h24,  1'b1, 1'b0, 1'b0, 32'h0);
        // Aliasing: not-taken update with other tag leaves entry alone.
        add(v_upd(v_idle(), 32'h20, 32'h100, 1'b1), 32'h28, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_upd(v_idle(), 32'h40, 32'h0, 1'b0),   32'h2C, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h20), 32'h20,  1'b1, 1'b1, 1'b1, 32'h100);
        // Overwrite by aliasing taken update; current cycle still uses old entry.
        add(v_upd(v_idle(), 32'h40, 32'h180, 1'b1), 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h20), 32'h20,  1'b1, 1'b1, 1'b0, 32'h0);
        add(v_idle(),         32'h24,  1'b1, 1'b0, 1'b0, 32'h0);
        // No bypass: training while at 0x20 does not steer this cycle.
        add(v_redir(v_idle(), 32'h20), 32'h20,  1'b1, 1'b1, 1'b0, 32'h0);
        add(v_upd(v_idle(), 32'h20, 32'h100, 1'b1), 32'h24, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h20), 32'h20,  1'b1, 1'b1, 1'b1, 32'h100);
        add(v_upd(v_idle(), 32'h20, 32'h0, 1'b0),   32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        // Wrap and alignment.
        add(v_redir(v_idle(), 32'hFFFFFFFE), 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 32'h0);
        add(v_idle(),         32'h0,   1'b1, 1'b0, 1'b0, 32'h0);
        add(v_upd(v_idle(), 32'h8, 32'h43, 1'b1), 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h8),  32'h8,   1'b1, 1'b1, 1'b1, 32'h40);
        add(v_trap(v_idle(), 32'h402), 32'h400, 1'b1, 1'b1, 1'b0, 32'h0);
        // Reset discards trap/redirect/update and clears the BTB.
        add(v_upd(v_redir(v_trap(v_rst(v_idle()), 32'h500), 32'h600), 32'h400, 32'h80, 1'b1),
            32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        add(v_redir(v_idle(), 32'h8),  32'h8,   1'b1, 1'b1, 1'b0, 32'h0);
        add(v_idle(),         32'hC,   1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            model_edge();
            @(posedge clk);
            #1;
            cmp($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                vecs[i].e_flush, vecs[i].e_pred, vecs[i].e_ptgt);
        end

        // Random stimulus against the reference model.
        for (int n = 0; n < 800; n++) begin
            v = v_idle();
            v.rst      = ($urandom % 97) == 0;
            v.stall    = ($urandom % 5) == 0;
            v.trap_v   = ($urandom % 13) == 0;
            v.trap_pc  = $urandom_range(0, 255);
            v.redir_v  = ($urandom % 9) == 0;
            v.redir_pc = (($urandom % 20) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15)
                                                 : $urandom_range(0, 255);
            v.upd_v    = ($urandom % 3) == 0;
            v.upd_pc   = $urandom_range(0, 127);
            v.upd_tgt  = $urandom_range(0, 255);
            v.upd_tk   = ($urandom % 4) != 0;
            drive(v);
            model_edge();
            @(posedge clk);
            #1;
            cmp($sformatf("rand%0d", n), m_pc, m_valid, m_flush, m_hit(m_pc), m_target(m_pc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen_btb.md
Name: pc_gen_btb

Overview:
Parametrised fetch-PC generator for the RISC-V core. It is the next generation of the plain PC register. It adds:
- a prioritised trap/redirect path,
- a direct-mapped branch target buffer (BTB) for next-PC prediction,
- a registered flush indication.

It sits at the head of the fetch stage and drives the instruction-fetch address and the valid strobe into IF.

Parameters:
ADDR_W, 32, width of PC and target addresses
RESET_PC, 32'h00000000, PC value loaded on reset; must be 4-aligned
BTB_DEPTH, 8, BTB entry count; power of two, at least 2
INC, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall_i  in  1  hold PC (pipeline lock from IF/ID)
trap_valid_i  in  1  trap/exception redirect request
trap_pc_i  in  ADDR_W  trap handler address
redirect_valid_i  in  1  branch-resolution redirect (mispredict) from EX
redirect_pc_i  in  ADDR_W  corrected PC
btb_upd_valid_i  in  1  BTB update strobe from EX
btb_upd_pc_i  in  ADDR_W  PC of the resolved control-transfer instruction
btb_upd_target_i  in  ADDR_W  resolved target
btb_upd_taken_i  in  1  resolved outcome: 1 = taken
pc_o  out  ADDR_W  current fetch PC
pc_valid_o  out  1  pc_o was updated at the last edge (new fetch)
pred_taken_o  out  1  BTB hit for pc_o (combinational)
pred_target_o  out  ADDR_W  BTB target for pc_o; 0 when no hit
flush_o  out  1  a trap or redirect was taken at the last edge

Behaviour:
- Reset, synchronous on rst=1 at posedge clk:
  - pc_o=RESET_PC, pc_valid_o=0, flush_o=0.
  - All BTB valid bits cleared; tags and targets left don't-care.
  - Reset mid-operation discards any pending trap, redirect or update in that cycle.
- Indexing:
  - IDX_W=log2(BTB_DEPTH); index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
  - hit = valid[index(pc_o)] && tag[index(pc_o)]==tag(pc_o).
  - pred_taken_o=hit; pred_target_o = hit ? target : 0.
- Next-PC priority, evaluated each cycle when rst=0; first match wins:
  1. trap_valid_i: pc_o<=trap_pc_i, pc_valid_o<=1, flush_o<=1.
  2. redirect_valid_i: pc_o<=redirect_pc_i, pc_valid_o<=1, flush_o<=1.
  3. stall_i: pc_o held, pc_valid_o<=0, flush_o<=0.
  4. BTB hit: pc_o<=BTB target, pc_valid_o<=1, flush_o<=0.
  5. Otherwise: pc_o<=pc_o+INC, pc_valid_o<=1, flush_o<=0.
- Trap and redirect override stall; trap overrides redirect when both are asserted in the same cycle.
- Alignment: bits [1:0] of every loaded address (trap, redirect, BTB target) are forced to 0, so pc_o[1:0] is always 00.
- Arithmetic: pc_o+INC is ADDR_W wide and wraps modulo 2^ADDR_W (all-ones-minus-3 + 4 -> 0).
- BTB update, applied at posedge when btb_upd_valid_i=1 and rst=0, at index(btb_upd_pc_i):
  - taken=1: valid<=1, tag<=tag(btb_upd_pc_i), target<=btb_upd_target_i (aligned). An existing entry is overwritten regardless of its tag.
  - taken=0 and entry valid with matching tag: valid<=0 (evict).
  - taken=0 and tag mismatch or entry invalid: no change.
- No write-to-read bypass: a lookup in the update cycle sees the old contents; the new entry is visible from the next cycle.
- Updates proceed independently of stall, trap and redirect in the same cycle.
- Latency: one cycle from request to pc_o change. pred_* follow pc_o combinationally in the same cycle.

Test Plan:
- Reset/sequential: assert rst 2 cycles, release with no other inputs -> pc_o 0,4,8,C on successive edges; pc_valid_o 0 after reset, then 1; pred_taken_o=0 throughout.
- Stall vs. redirect: stall_i=1 for 3 cycles at pc_o=0x10 -> pc_o holds 0x10 with pc_valid_o=0. Then stall_i=1 with redirect_valid_i=1 to 0x200 -> pc_o=0x200, pc_valid_o=1, flush_o=1 for exactly one cycle.
- Priority: trap to 0x80 and redirect to 0x300 in the same cycle -> pc_o=0x80, flush_o=1.
- BTB train/predict: update pc=0x20, target=0x100, taken=1. Later reach pc_o=0x20 -> pred_taken_o=1, pred_target_o=0x100, next pc_o=0x100. An update at pc=0x20 with taken=0 evicts the entry, and the next visit to 0x20 proceeds to 0x24.
- Aliasing/no bypass:
  - Train 0x20->0x100, then update 0x40 (same index for DEPTH=8, different tag) taken=0 -> entry unchanged.
  - Update 0x40->0x180 taken=1 -> a later visit to 0x20 misses.
  - An update issued in the same cycle as pc_o=0x20 is not used for that cycle's next-PC.
- Wrap/alignment: redirect to 0xFFFFFFFE -> pc_o=0xFFFFFFFC, next pc_o=0x00000000. A trap mid-stream followed by rst=1 -> pc_o=RESET_PC and all prior BTB entries miss.
